soc_run_ctrl: RTL

SOC_RUN_CTRL -- requirements
Module: soc_run_ctrl

---
 rtl/soc_run_ctrl_pkg.sv | 18 +
 rtl/soc_run_ctrl_ld_arbiter.sv | 100 ++++++++++
 rtl/soc_run_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/soc_run_ctrl_pkg.sv
// Shared types and helpers for the SoC run controller (boot load, core reset hold, refresh pacing).

package soc_run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_LOAD,
    S_HOLD,
    S_START,
    S_RUN
  } run_state_e;

  // Bit width needed to index/hold n values; never returns 0 so degenerate params stay legal.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/soc_run_ctrl_ld_arbiter.sv
// Loader arbiter: first-come lowest-index claim, owner hold until cleared, memory bus mux.

module ld_arbiter
  import soc_run_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_LD = 2,
  parameter int unsigned SRC_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     active_i,
  input  logic                     clear_i,
  input  logic [NUM_LD-1:0]        ld_valid_i,
  input  logic [NUM_LD*ADDR_W-1:0] ld_addr_i,
  input  logic [NUM_LD*DATA_W-1:0] ld_data_i,
  input  logic [NUM_LD-1:0]        ld_done_i,
  input  logic [ADDR_W-1:0]        core_addr_i,
  input  logic                     core_we_i,
  input  logic [DATA_W-1:0]        core_wdata_i,
  output logic [NUM_LD-1:0]        ld_ready_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic                     mem_we_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic                     wr_acc_o,
  output logic                     own_done_o,
  output logic [SRC_W-1:0]         src_o
);

  logic             own_vld_q;
  logic [SRC_W-1:0] own_idx_q;
  logic [SRC_W-1:0] low_idx;
  logic [SRC_W-1:0] sel_idx;
  logic             any_vld;
  logic             own_valid;
  logic             own_done;

  // Lowest-index requester, plus the owner's own request/done bits.
  always_comb begin
    low_idx   = '0;
    any_vld   = 1'b0;
    own_valid = 1'b0;
    own_done  = 1'b0;
    for (int i = int'(NUM_LD) - 1; i >= 0; i--) begin
      if (ld_valid_i[i]) begin
        low_idx = SRC_W'(i);
        any_vld = 1'b1;
      end
      if (own_idx_q == SRC_W'(i)) begin
        own_valid = ld_valid_i[i];
        own_done  = ld_done_i[i];
      end
    end
  end

  assign sel_idx    = own_vld_q ? own_idx_q : low_idx;
  assign wr_acc_o   = active_i && (own_vld_q ? own_valid : any_vld);
  assign own_done_o = active_i && own_vld_q && own_done;
  assign src_o      = own_idx_q;

  always_comb begin
    ld_ready_o = '0;
    for (int i = 0; i < int'(NUM_LD); i++) begin
      ld_ready_o[i] = active_i && (!own_vld_q || (own_idx_q == SRC_W'(i)));
    end
  end

  // Outside the load phase the CPU owns the memory bus.
  always_comb begin
    mem_addr_o  = core_addr_i;
    mem_wdata_o = core_wdata_i;
    mem_we_o    = core_we_i;
    if (active_i) begin
      mem_we_o    = wr_acc_o;
      mem_addr_o  = ld_addr_i[ADDR_W-1:0];
      mem_wdata_o = ld_data_i[DATA_W-1:0];
      for (int i = 0; i < int'(NUM_LD); i++) begin
        if (sel_idx == SRC_W'(i)) begin
          mem_addr_o  = ld_addr_i[i*ADDR_W +: ADDR_W];
          mem_wdata_o = ld_data_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_vld_q <= 1'b0;
      own_idx_q <= '0;
    end else if (clear_i) begin
      own_vld_q <= 1'b0;
      own_idx_q <= '0;
    end else if (active_i && !own_vld_q && any_vld) begin
      own_vld_q <= 1'b1;
      own_idx_q <= low_idx;
    end
  end

endmodule

// File: rtl/soc_run_ctrl.sv
// SoC run controller: loader phase, core reset hold/start, run with refresh strobes.
// Define SOC_RUN_CTRL_RELOAD_EN to let any loader request in S_RUN re-enter the load phase.

module soc_run_ctrl
  import soc_run_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W           = 16,
  parameter int unsigned DATA_W           = 8,
  parameter int unsigned NUM_LD           = 2,
  parameter int unsigned LOAD_TIMEOUT_CYC = 100_000_000,
  parameter int unsigned HOLD_CYC         = 16,
  parameter int unsigned REFRESH_CYC      = 2_500_000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              soft_reset_n,
  input  logic [NUM_LD-1:0]                 ld_valid,
  input  logic [NUM_LD*ADDR_W-1:0]          ld_addr,
  input  logic [NUM_LD*DATA_W-1:0]          ld_data,
  input  logic [NUM_LD-1:0]                 ld_done,
  output logic [NUM_LD-1:0]                 ld_ready,
  input  logic [ADDR_W-1:0]                 core_addr,
  input  logic                              core_we,
  input  logic [DATA_W-1:0]                 core_wdata,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic                              mem_we,
  output logic [DATA_W-1:0]                 mem_wdata,
  output logic                              core_en,
  output logic                              core_rst_n,
  output logic                              load_active,
  output logic [clog2_safe(NUM_LD)-1:0]     load_src,
  input  logic                              periph_idle,
  output logic                              refresh_stb
);

  localparam int unsigned SRC_W  = clog2_safe(NUM_LD);
  localparam int unsigned TMO_W  = clog2_safe(LOAD_TIMEOUT_CYC + 32'd1);
  localparam int unsigned HOLD_W = clog2_safe(HOLD_CYC + 32'd1);
  localparam int unsigned REF_W  = clog2_safe(REFRESH_CYC + 32'd1);

  localparam logic [TMO_W-1:0]  TMO_INIT  = TMO_W'(LOAD_TIMEOUT_CYC);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC);
  localparam logic [REF_W-1:0]  REF_INIT  = REF_W'(REFRESH_CYC);

  run_state_e        state_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [HOLD_W-1:0] hold_q;
  logic [REF_W-1:0]  ref_q;
  logic              pend_q;
  logic              core_en_q;
  logic              core_rst_n_q;
  logic              stb_q;

  logic [TMO_W-1:0]  tmo_dec;
  logic [TMO_W-1:0]  tmo_nxt;
  logic [HOLD_W-1:0] hold_dec;
  logic [REF_W-1:0]  ref_dec;
  logic              ref_exp;
  logic              wr_acc;
  logic              own_done;
  logic              load_exit;

  assign load_active = (state_q == S_LOAD);
  assign core_en     = core_en_q;
  assign core_rst_n  = core_rst_n_q;
  assign refresh_stb = stb_q;

  ld_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_LD (NUM_LD),
    .SRC_W  (SRC_W)
  ) u_ld_arbiter (
    .clk          (clk),
    .rst_n        (rst_n),
    .active_i     (load_active),
    .clear_i      (load_exit),
    .ld_valid_i   (ld_valid),
    .ld_addr_i    (ld_addr),
    .ld_data_i    (ld_data),
    .ld_done_i    (ld_done),
    .core_addr_i  (core_addr),
    .core_we_i    (core_we),
    .core_wdata_i (core_wdata),
    .ld_ready_o   (ld_ready),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .wr_acc_o     (wr_acc),
    .own_done_o   (own_done),
    .src_o        (load_src)
  );

  // Saturating decrements; a counter at 0 stays at 0.
  always_comb begin
    tmo_dec  = (tmo_q  == '0) ? '0 : tmo_q  - TMO_W'(1);
    hold_dec = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
    ref_dec  = (ref_q  == '0) ? '0 : ref_q  - REF_W'(1);
    tmo_nxt  = wr_acc ? TMO_INIT : (soft_reset_n ? tmo_dec : tmo_q);
    ref_exp  = (ref_dec == '0);
    load_exit = load_active && (own_done || (tmo_nxt == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      tmo_q        <= '0;
      hold_q       <= '0;
      ref_q        <= '0;
      pend_q       <= 1'b0;
      core_en_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      stb_q        <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          state_q <= S_LOAD;
          tmo_q   <= TMO_INIT;
        end
        S_LOAD: begin
          tmo_q <= tmo_nxt;
          if (load_exit) begin
            state_q <= S_HOLD;
            hold_q  <= HOLD_INIT;
          end
        end
        // Hold count restarts while the user keeps soft reset asserted.
        S_HOLD: begin
          if (!soft_reset_n) begin
            hold_q <= HOLD_INIT;
          end else if (hold_dec == '0) begin
            state_q <= S_START;
          end else begin
            hold_q <= hold_dec;
          end
        end
        S_START: begin
          core_en_q    <= 1'b1;
          core_rst_n_q <= 1'b1;
          ref_q        <= REF_INIT;
          state_q      <= S_RUN;
        end
        S_RUN: begin
          if (!soft_reset_n) begin
            state_q      <= S_HOLD;
            hold_q       <= HOLD_INIT;
            core_en_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            pend_q       <= 1'b0;
`ifdef SOC_RUN_CTRL_RELOAD_EN
          end else if (|ld_valid) begin
            state_q      <= S_LOAD;
            tmo_q        <= TMO_INIT;
            core_en_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            pend_q       <= 1'b0;
`endif
          end else begin
            ref_q <= ref_exp ? REF_INIT : ref_dec;
            // A single pending slot: expiries while already pending are dropped.
            if (periph_idle && (pend_q || ref_exp)) begin
              stb_q  <= 1'b1;
              pend_q <= 1'b0;
            end else if (ref_exp) begin
              pend_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule
